// File: rtl/shreg_pkg.sv
// Shared types for the shift-sequence controller: command ops, FSM states
// and the datapath mode that the controller drives into the shift register.
package shreg_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_LOAD,
    MODE_SHL,
    MODE_SHR,
    MODE_ROL
  } mode_e;

  // Shift mode used for a command op while stepping; load-only never shifts.
  function automatic mode_e mode_of(op_e op);
    case (op)
      OP_SHL:  return MODE_SHL;
      OP_SHR:  return MODE_SHR;
      OP_ROL:  return MODE_ROL;
      default: return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/univ_shreg.sv
// Universal shift register: hold, parallel load, shift left/right with a
// serial fill bit, or rotate left.
module univ_shreg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      case (mode)
        MODE_LOAD: out <= par_in;
        MODE_SHL:  out <= {out[WIDTH-2:0], ser_in};
        MODE_SHR:  out <= {ser_in, out[WIDTH-1:1]};
        MODE_ROL:  out <= {out[WIDTH-2:0], out[WIDTH-1]};
        default:   out <= out;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven shift sequencer: accepts one load/shift command at a time,
// loads the register, then steps it count times before pulsing done.
module shift_seq_ctrl
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  op_e              op_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] data_q;
  mode_e            mode;

  // NOTE: reset is synchronous and clears every register, including the
  // captured command, so a reset mid-command leaves no stale state behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_LOAD;
      count_q   <= '0;
      data_q    <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cmd_valid) begin
        op_q    <= op_e'(cmd_op);
        count_q <= cmd_count;
        data_q  <= cmd_data;
      end
      if (state == ST_LOAD)
        remaining <= count_q;
      else if (state == ST_SHIFT)
        remaining <= remaining - CNT_W'(1);
    end
  end

  // NOTE: defaults come first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        mode = MODE_LOAD;
        if (op_q == OP_LOAD || count_q == '0)
          state_nxt = ST_DONE;
        else
          state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        mode = mode_of(op_q);
        // The step that takes remaining from 1 to 0 is the last one.
        if (remaining == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  univ_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .par_in (data_q),
    .ser_in (ser_in),
    .out    (out)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at WIDTH=4, CNT_W=3 with hand-computed
// register contents and done timing.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic       ser_in;
  logic [3:0] out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] exp_out, input logic exp_done);
    tick();
    check({tag, " out"}, 32'(out), 32'(exp_out));
    check({tag, " done"}, 32'(done), 32'(exp_done));
  endtask

  // Present a command, wait (bounded) for acceptance, then scramble the
  // command inputs so any late sampling would show up in out.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
    int waited = 0;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cmd_ready) check("accept timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_count = ~cnt;
    cmd_data  = ~data;
    check("busy after accept", 32'(busy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 3'd0;
    cmd_data = 4'h0; ser_in = 1'b0;
    tick();
    tick();
    check("reset out", 32'(out), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    #1;
    check("reset ready", 32'(cmd_ready), 32'd1);

    // Shift left, count 2, fill 1
    ser_in = 1'b1;
    issue(2'b01, 3'd2, 4'b1010);
    check("shl ready busy", 32'(cmd_ready), 32'd0);
    step("shl e1", 4'b1010, 1'b0);
    step("shl e2", 4'b0101, 1'b0);
    step("shl e3", 4'b1011, 1'b1);
    step("shl idle", 4'b1011, 1'b0);
    check("shl ready", 32'(cmd_ready), 32'd1);

    // Shift right, count 2, fill 0
    ser_in = 1'b0;
    issue(2'b10, 3'd2, 4'b1001);
    step("shr e1", 4'b1001, 1'b0);
    step("shr e2", 4'b0100, 1'b0);
    step("shr e3", 4'b0010, 1'b1);
    step("shr idle", 4'b0010, 1'b0);

    // Rotate left, count 3, ser_in toggling must not matter
    ser_in = 1'b1;
    issue(2'b11, 3'd3, 4'b1110);
    step("rol e1", 4'b1110, 1'b0);
    ser_in = 1'b0;
    step("rol e2", 4'b1101, 1'b0);
    ser_in = 1'b1;
    step("rol e3", 4'b1011, 1'b0);
    ser_in = 1'b0;
    step("rol e4", 4'b0111, 1'b1);
    step("rol idle", 4'b0111, 1'b0);

    // Load-only ignores a nonzero count
    issue(2'b00, 3'd5, 4'b0010);
    step("ld e1", 4'b0010, 1'b1);
    step("ld idle", 4'b0010, 1'b0);
    check("ld busy idle", 32'(busy), 32'd0);

    // Shift with count 0 behaves like load-only
    ser_in = 1'b1;
    issue(2'b01, 3'd0, 4'b0110);
    step("cnt0 e1", 4'b0110, 1'b1);
    step("cnt0 idle", 4'b0110, 1'b0);

    // Maximum count: exactly 7 rotations of 0001 -> 1000
    issue(2'b11, 3'd7, 4'b0001);
    step("max e1", 4'b0001, 1'b0);
    step("max e2", 4'b0010, 1'b0);
    step("max e3", 4'b0100, 1'b0);
    step("max e4", 4'b1000, 1'b0);
    step("max e5", 4'b0001, 1'b0);
    step("max e6", 4'b0010, 1'b0);
    step("max e7", 4'b0100, 1'b0);
    step("max e8", 4'b1000, 1'b1);
    step("max idle", 4'b1000, 1'b0);

    // Reset mid-operation aborts with no done pulse
    ser_in = 1'b1;
    issue(2'b01, 3'd7, 4'b1000);
    step("rst e1", 4'b1000, 1'b0);
    step("rst e2", 4'b0001, 1'b0);
    step("rst e3", 4'b0011, 1'b0);
    rst = 1'b1;
    step("rst edge", 4'b0000, 1'b0);
    rst = 1'b0;
    #1;
    check("rst ready", 32'(cmd_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step("rst quiet", 4'b0000, 1'b0);

    // Fresh command after reset completes normally
    issue(2'b11, 3'd1, 4'b0011);
    step("post e1", 4'b0011, 1'b0);
    step("post e2", 4'b0110, 1'b1);
    step("post idle", 4'b0110, 1'b0);

    // Busy rejection: second command held valid throughout a count-4 shift
    ser_in    = 1'b0;
    cmd_op    = 2'b10;
    cmd_count = 3'd4;
    cmd_data  = 4'b1111;
    cmd_valid = 1'b1;
    tick();
    cmd_op    = 2'b00;
    cmd_count = 3'd0;
    cmd_data  = 4'b0101;
    check("bz ready", 32'(cmd_ready), 32'd0);
    step("bz e1", 4'b1111, 1'b0);
    step("bz e2", 4'b0111, 1'b0);
    check("bz ready mid", 32'(cmd_ready), 32'd0);
    step("bz e3", 4'b0011, 1'b0);
    step("bz e4", 4'b0001, 1'b0);
    step("bz e5", 4'b0000, 1'b1);
    check("bz ready done", 32'(cmd_ready), 32'd0);
    step("bz idle", 4'b0000, 1'b0);
    check("bz ready idle", 32'(cmd_ready), 32'd1);
    step("bz accept2", 4'b0000, 1'b0);
    check("bz busy2", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    step("bz load2", 4'b0101, 1'b1);
    step("bz idle2", 4'b0101, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: data width of the controlled register.
REQ-002 Parameter CNT_W, default 3: shift-count width; maximum count is 2**CNT_W-1.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 cmd_op  input  2  operation: 00 load-only, 01 shift left, 10 shift right, 11 rotate left.
REQ-009 cmd_count  input  CNT_W  number of single-bit shift steps.
REQ-010 cmd_data  input  WIDTH  parallel load value.
REQ-011 ser_in  input  1  serial fill bit for shift left and shift right.
REQ-012 out  output  WIDTH  parallel register contents.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-017 On acceptance (edge E0), the block SHALL capture cmd_op, cmd_count and cmd_data into internal registers and enter LOAD; later changes to the cmd_* inputs SHALL have no effect.
REQ-018 In LOAD, at edge E1, out SHALL take the captured data. The next state SHALL be DONE if op=00 or count=0; otherwise it SHALL be SHIFT, with remaining=count.
REQ-019 In SHIFT, each edge SHALL perform exactly one step and decrement remaining. The FSM SHALL move to DONE on the edge where remaining goes from 1 to 0.
REQ-020 The shift steps SHALL be:
- shift left: out <= {out[WIDTH-2:0], ser_in}
- shift right: out <= {ser_in, out[WIDTH-1:1]}
- rotate left: out <= {out[WIDTH-2:0], out[WIDTH-1]}, with ser_in ignored.
REQ-021 ser_in SHALL be sampled on each shift edge; it is not captured at acceptance.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-023 Latency: done SHALL be high in the cycle after edge E(1+N) for a shift command with count N>0, and in the cycle after E1 for load-only or count=0.
REQ-024 Minimum command-to-command spacing SHALL be N+3 cycles.
REQ-025 out SHALL hold its value in IDLE and DONE, and SHALL remain valid after done until the next LOAD.
REQ-026 The count SHALL not saturate or wrap: the maximum count (7 at the defaults) performs exactly 7 steps.
REQ-027 cmd_valid asserted while busy SHALL be ignored; the block does not queue commands.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set state=IDLE, out=0, done=0, busy=0, remaining=0 and clear all captured command registers.
REQ-029 Reset SHALL take priority over any command acceptance or shift on the same edge.
REQ-030 Reset mid-operation SHALL abort the command with no done pulse; cmd_ready SHALL be 1 in the cycle after the reset edge once rst is low.

Structure
REQ-031 Shared package shreg_pkg SHALL hold:
- the op encoding typedef (OP_LOAD, OP_SHL, OP_SHR, OP_ROL)
- the FSM state typedef.
REQ-032 The datapath SHALL be one sub-module, univ_shreg: a WIDTH-bit register with clk, rst, mode (hold/load/shl/shr/rol), par_in, ser_in and out. shift_seq_ctrl drives its mode.

Verification (WIDTH=4, CNT_W=3)
REQ-033 Load/shift left: op=01, count=2, data=1010, ser_in=1 -> out=1010 after E1, 0101 after E2, 1011 after E3; done high in the following cycle.
REQ-034 Shift right: op=10, count=2, data=1001, ser_in=0 -> out sequence 1001, 0100, 0010; done after E3.
REQ-035 Rotate left: op=11, count=3, data=1110, ser_in toggling -> out sequence 1110, 1101, 1011, 0111; ser_in has no effect.
REQ-036 Load-only and count=0: op=00, count=5, data=0010 -> out=0010 with done in the cycle after E1. Separately, op=01, count=0 gives the same timing and out=data.
REQ-037 Reset mid-operation: op=01, count=7, data=1000; assert rst for one cycle after E3 -> out=0000, no done pulse, cmd_ready=1 next cycle. A fresh command then completes normally.
REQ-038 Busy rejection: a second cmd_valid held during a count=4 command -> cmd_ready=0, the second command is not accepted until IDLE, and out is unaffected.
